// File: rtl/theremin_period_arbiter_if.sv
// Bundles the two measurement inputs, the output handshake and the drop counters
// of theremin_period_arbiter.
// master: measurement producers and consumer side (testbench / surrounding logic)
// slave : the arbiter itself
interface theremin_period_arbiter_if #(
    parameter int unsigned PERIOD_BITS = 16,
    parameter int unsigned DROP_BITS   = 8
);
    logic                   CH0_VALID;
    logic [PERIOD_BITS-1:0] CH0_PERIOD;
    logic                   CH1_VALID;
    logic [PERIOD_BITS-1:0] CH1_PERIOD;
    logic                   OUT_READY;
    logic                   CLEAR_DROPS;
    logic                   OUT_VALID;
    logic                   OUT_CHANNEL;
    logic [PERIOD_BITS-1:0] OUT_PERIOD;
    logic [DROP_BITS-1:0]   CH0_DROPS;
    logic [DROP_BITS-1:0]   CH1_DROPS;

    modport master (
        output CH0_VALID, CH0_PERIOD, CH1_VALID, CH1_PERIOD, OUT_READY, CLEAR_DROPS,
        input  OUT_VALID, OUT_CHANNEL, OUT_PERIOD, CH0_DROPS, CH1_DROPS
    );

    modport slave (
        input  CH0_VALID, CH0_PERIOD, CH1_VALID, CH1_PERIOD, OUT_READY, CLEAR_DROPS,
        output OUT_VALID, OUT_CHANNEL, OUT_PERIOD, CH0_DROPS, CH1_DROPS
    );
endinterface

// File: rtl/theremin_period_arbiter.sv
// Merges the pitch (channel 0) and volume (channel 1) half-period streams into one
// tagged, registered valid/ready stream. Each channel is buffered in its own FIFO;
// a round-robin arbiter pops one head per free output cycle. Measurements arriving
// at a full FIFO are dropped and counted in a saturating per-channel counter.
// Ports:
//   CLK_PARALLEL  clock, rising edge
//   RESET         synchronous, active-high
//   bus           theremin_period_arbiter_if.slave (CHn_VALID/CHn_PERIOD in,
//                 OUT_VALID/OUT_CHANNEL/OUT_PERIOD/OUT_READY handshake,
//                 CLEAR_DROPS in, CH0_DROPS/CH1_DROPS out)
module theremin_period_arbiter #(
    parameter int unsigned PERIOD_BITS = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned DROP_BITS   = 8
) (
    input  logic                          CLK_PARALLEL,
    input  logic                          RESET,
    theremin_period_arbiter_if.slave      bus
);
    localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0]  CNT_FULL = CNT_BITS'(FIFO_DEPTH);
    localparam logic [DROP_BITS-1:0] DROP_MAX = {DROP_BITS{1'b1}};

    // Per-channel FIFO storage and state
    logic [PERIOD_BITS-1:0] mem     [2][FIFO_DEPTH];
    logic [PTR_BITS-1:0]    wr_ptr  [2];
    logic [PTR_BITS-1:0]    rd_ptr  [2];
    logic [CNT_BITS-1:0]    count   [2];
    logic [DROP_BITS-1:0]   drops   [2];

    // Output register and arbitration state
    logic                   out_valid;
    logic                   out_channel;
    logic [PERIOD_BITS-1:0] out_period;
    logic                   last_grant;

    // Combinational helpers
    logic                   in_valid_c  [2];
    logic [PERIOD_BITS-1:0] in_period_c [2];
    logic [PERIOD_BITS-1:0] head_c      [2];
    logic                   nonempty_c  [2];
    logic                   push_c      [2];
    logic                   pop_c       [2];
    logic                   drop_c      [2];
    logic                   out_free_c;
    logic                   any_c;
    logic                   tie_c;
    logic                   grant_c;

    assign in_valid_c[0]  = bus.CH0_VALID;
    assign in_valid_c[1]  = bus.CH1_VALID;
    assign in_period_c[0] = bus.CH0_PERIOD;
    assign in_period_c[1] = bus.CH1_PERIOD;

    // Arbitration, push/pop/drop decisions
    always_comb begin
        out_free_c = !out_valid || bus.OUT_READY;
        for (int i = 0; i < 2; i++) begin
            nonempty_c[i] = (count[i] != '0);
            head_c[i]     = mem[i][rd_ptr[i]];
        end
        any_c   = nonempty_c[0] || nonempty_c[1];
        tie_c   = nonempty_c[0] && nonempty_c[1];
        // Tie goes to the channel not granted last; otherwise the only non-empty one
        grant_c = tie_c ? !last_grant : nonempty_c[1];
        for (int i = 0; i < 2; i++) begin
            pop_c[i]  = out_free_c && nonempty_c[i] && (grant_c == 1'(i));
            // A full FIFO still accepts a write when its head leaves in the same cycle
            push_c[i] = in_valid_c[i] && ((count[i] != CNT_FULL) || pop_c[i]);
            drop_c[i] = in_valid_c[i] && !push_c[i];
        end
    end

    // FIFOs, drop counters and output register
    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                drops[i]  <= '0;
            end
            out_valid   <= 1'b0;
            out_channel <= 1'b0;
            out_period  <= '0;
            last_grant  <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_c[i]) begin
                    mem[i][wr_ptr[i]] <= in_period_c[i];
                    wr_ptr[i]         <= wr_ptr[i] + PTR_BITS'(1);
                end
                if (pop_c[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_BITS'(1);
                end
                count[i] <= count[i] + CNT_BITS'(push_c[i]) - CNT_BITS'(pop_c[i]);

                // Clear wins over the old value but still records a same-cycle drop
                if (bus.CLEAR_DROPS) begin
                    drops[i] <= DROP_BITS'(drop_c[i]);
                end else if (drop_c[i] && (drops[i] != DROP_MAX)) begin
                    drops[i] <= drops[i] + DROP_BITS'(1);
                end
            end

            if (out_free_c) begin
                out_valid <= any_c;
                if (any_c) begin
                    out_channel <= grant_c;
                    out_period  <= head_c[grant_c];
                end
                if (tie_c) begin
                    last_grant <= grant_c;
                end
            end
        end
    end

    assign bus.OUT_VALID   = out_valid;
    assign bus.OUT_CHANNEL = out_channel;
    assign bus.OUT_PERIOD  = out_period;
    assign bus.CH0_DROPS   = drops[0];
    assign bus.CH1_DROPS   = drops[1];
endmodule

// File: tb/tb_theremin_period_arbiter.sv
// Directed, table-driven bench for theremin_period_arbiter (PERIOD_BITS=16,
// FIFO_DEPTH=4, DROP_BITS=8) with hand-written multi-cycle sequences.
module tb_theremin_period_arbiter;
    logic clk;
    logic rst;

    theremin_period_arbiter_if #(.PERIOD_BITS(16), .DROP_BITS(8)) bus ();

    theremin_period_arbiter #(
        .PERIOD_BITS(16),
        .FIFO_DEPTH (4),
        .DROP_BITS  (8)
    ) dut (
        .CLK_PARALLEL(clk),
        .RESET       (rst),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [15:0] p0;
        logic        v1;
        logic [15:0] p1;
        logic        rdy;
        logic        clr;
        logic        ev;   // expected OUT_VALID
        logic        cd;   // compare OUT_CHANNEL/OUT_PERIOD
        logic        ec;
        logic [15:0] ep;
        logic [7:0]  ed0;
        logic [7:0]  ed1;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    int passed = 0;
    int total  = 0;

    function automatic vec_t mk(logic r, logic v0, logic [15:0] p0, logic v1, logic [15:0] p1,
                                logic rdy, logic clr, logic ev, logic cd, logic ec,
                                logic [15:0] ep, logic [7:0] ed0, logic [7:0] ed1);
        vec_t v;
        v.rst = r;  v.v0 = v0; v.p0 = p0; v.v1 = v1; v.p1 = p1;
        v.rdy = rdy; v.clr = clr; v.ev = ev; v.cd = cd; v.ec = ec;
        v.ep = ep; v.ed0 = ed0; v.ed1 = ed1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic r, input logic v0, input logic [15:0] p0,
                         input logic v1, input logic [15:0] p1, input logic rdy, input logic clr);
        rst             = r;
        bus.CH0_VALID   = v0;
        bus.CH0_PERIOD  = p0;
        bus.CH1_VALID   = v1;
        bus.CH1_PERIOD  = p1;
        bus.OUT_READY   = rdy;
        bus.CLEAR_DROPS = clr;
    endtask

    // Advance one clock and sample just after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string name, input logic ch, input logic [15:0] p);
        chk({name, "_valid"},   32'(bus.OUT_VALID), 32'd1);
        chk({name, "_channel"}, 32'(bus.OUT_CHANNEL), 32'(ch));
        chk({name, "_period"},  32'(bus.OUT_PERIOD), 32'(p));
    endtask

    int d0, d1, diff;
    logic exp_ch;

    initial begin
        // rst v0 p0 v1 p1 rdy clr | ev cd ec ep ed0 ed1
        vecs[0]  = mk(1, 0, 16'h0,    0, 16'h0, 1, 0,  0, 1, 0, 16'h0,    0, 0); // reset state
        vecs[1]  = mk(0, 1, 16'h1234, 0, 16'h0, 1, 0,  0, 0, 0, 16'h0,    0, 0); // single word in
        vecs[2]  = mk(0, 0, 16'h0,    0, 16'h0, 1, 0,  1, 1, 0, 16'h1234, 0, 0); // N+2
        vecs[3]  = mk(0, 0, 16'h0,    0, 16'h0, 1, 0,  0, 0, 0, 16'h0,    0, 0); // one cycle only
        vecs[4]  = mk(1, 0, 16'h0,    0, 16'h0, 1, 0,  0, 1, 0, 16'h0,    0, 0);
        vecs[5]  = mk(0, 1, 16'd100,  1, 16'd200, 1, 0, 0, 0, 0, 16'h0,   0, 0); // tie
        vecs[6]  = mk(0, 0, 16'h0,    0, 16'h0, 1, 0,  1, 1, 0, 16'd100,  0, 0);
        vecs[7]  = mk(0, 0, 16'h0,    0, 16'h0, 1, 0,  1, 1, 1, 16'd200,  0, 0);
        vecs[8]  = mk(0, 0, 16'h0,    0, 16'h0, 1, 0,  0, 0, 0, 16'h0,    0, 0);
        vecs[9]  = mk(0, 0, 16'h0,    1, 16'd1, 0, 0,  0, 0, 0, 16'h0,    0, 0); // backpressure
        vecs[10] = mk(0, 0, 16'h0,    1, 16'd2, 0, 0,  1, 1, 1, 16'd1,    0, 0);
        vecs[11] = mk(0, 0, 16'h0,    1, 16'd3, 0, 0,  1, 1, 1, 16'd1,    0, 0);
        vecs[12] = mk(0, 0, 16'h0,    1, 16'd4, 0, 0,  1, 1, 1, 16'd1,    0, 0);
        vecs[13] = mk(0, 0, 16'h0,    1, 16'd5, 0, 0,  1, 1, 1, 16'd1,    0, 0);
        vecs[14] = mk(0, 0, 16'h0,    1, 16'd6, 0, 0,  1, 1, 1, 16'd1,    0, 1); // dropped
        vecs[15] = mk(0, 0, 16'h0,    0, 16'h0, 0, 0,  1, 1, 1, 16'd1,    0, 1); // stable while stalled
        vecs[16] = mk(0, 0, 16'h0,    0, 16'h0, 1, 0,  1, 1, 1, 16'd2,    0, 1);
        vecs[17] = mk(0, 0, 16'h0,    0, 16'h0, 1, 0,  1, 1, 1, 16'd3,    0, 1);
        vecs[18] = mk(0, 0, 16'h0,    0, 16'h0, 1, 0,  1, 1, 1, 16'd4,    0, 1);
        vecs[19] = mk(0, 0, 16'h0,    0, 16'h0, 1, 0,  1, 1, 1, 16'd5,    0, 1);
        vecs[20] = mk(0, 0, 16'h0,    0, 16'h0, 1, 0,  0, 0, 0, 16'h0,    0, 1);
        vecs[21] = mk(0, 0, 16'h0,    0, 16'h0, 1, 1,  0, 0, 0, 16'h0,    0, 0); // clear

        drive(1, 0, 16'h0, 0, 16'h0, 0, 0);
        cyc();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].v0, vecs[i].p0, vecs[i].v1, vecs[i].p1,
                  vecs[i].rdy, vecs[i].clr);
            cyc();
            chk($sformatf("vec%0d_valid", i), 32'(bus.OUT_VALID), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_drops0", i), 32'(bus.CH0_DROPS), 32'(vecs[i].ed0));
            chk($sformatf("vec%0d_drops1", i), 32'(bus.CH1_DROPS), 32'(vecs[i].ed1));
            if (vecs[i].cd) begin
                chk($sformatf("vec%0d_channel", i), 32'(bus.OUT_CHANNEL), 32'(vecs[i].ec));
                chk($sformatf("vec%0d_period", i), 32'(bus.OUT_PERIOD), 32'(vecs[i].ep));
            end
        end

        // Fairness: both channels every cycle, consumer always ready
        drive(1, 0, 16'h0, 0, 16'h0, 1, 0);
        cyc();
        exp_ch = 1'b0;
        for (int k = 0; k < 40; k++) begin
            drive(0, 1, 16'(k), 1, 16'(1000 + k), 1, 0);
            cyc();
            if (k == 0) begin
                chk("fair_first_valid", 32'(bus.OUT_VALID), 32'd0);
            end else begin
                chk($sformatf("fair%0d_valid", k), 32'(bus.OUT_VALID), 32'd1);
                chk($sformatf("fair%0d_channel", k), 32'(bus.OUT_CHANNEL), 32'(exp_ch));
                exp_ch = !exp_ch;
            end
        end
        d0   = int'(bus.CH0_DROPS);
        d1   = int'(bus.CH1_DROPS);
        diff = (d0 > d1) ? d0 - d1 : d1 - d0;
        chk("fair_drops_nonzero", 32'(d0 > 0 && d1 > 0), 32'd1);
        chk("fair_drops_equal", 32'(diff <= 1), 32'd1);

        // Saturation: 305 CH0 pulses against a stalled consumer -> 300 drops
        drive(1, 0, 16'h0, 0, 16'h0, 0, 0);
        cyc();
        for (int k = 1; k <= 305; k++) begin
            drive(0, 1, 16'(k), 0, 16'h0, 0, 0);
            cyc();
        end
        chk("sat_drops0", 32'(bus.CH0_DROPS), 32'd255);
        chk("sat_drops1", 32'(bus.CH1_DROPS), 32'd0);
        chk_word("sat_hold", 1'b0, 16'd1);

        // Clear together with a drop leaves a count of one
        drive(0, 1, 16'd999, 0, 16'h0, 0, 1);
        cyc();
        chk("clr_drop_drops0", 32'(bus.CH0_DROPS), 32'd1);

        // Full FIFO written while popped: accepted, no drop
        drive(0, 1, 16'd777, 0, 16'h0, 1, 0);
        cyc();
        chk_word("fullpop_w2", 1'b0, 16'd2);
        chk("fullpop_drops0", 32'(bus.CH0_DROPS), 32'd1);
        drive(0, 0, 16'h0, 0, 16'h0, 1, 0);
        cyc(); chk_word("fullpop_w3", 1'b0, 16'd3);
        cyc(); chk_word("fullpop_w4", 1'b0, 16'd4);
        cyc(); chk_word("fullpop_w5", 1'b0, 16'd5);
        cyc(); chk_word("fullpop_w777", 1'b0, 16'd777);
        cyc(); chk("fullpop_empty", 32'(bus.OUT_VALID), 32'd0);

        // Reset mid-stream with three words buffered
        drive(1, 0, 16'h0, 0, 16'h0, 0, 0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 16'(11 + k), 0, 16'h0, 0, 0);
            cyc();
        end
        chk_word("mid_before", 1'b0, 16'd11);
        drive(1, 0, 16'h0, 1, 16'd44, 0, 0);
        cyc();
        chk("mid_rst_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("mid_rst_channel", 32'(bus.OUT_CHANNEL), 32'd0);
        chk("mid_rst_period", 32'(bus.OUT_PERIOD), 32'd0);
        chk("mid_rst_drops0", 32'(bus.CH0_DROPS), 32'd0);
        chk("mid_rst_drops1", 32'(bus.CH1_DROPS), 32'd0);
        drive(0, 0, 16'h0, 0, 16'h0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("mid_stale%0d", k), 32'(bus.OUT_VALID), 32'd0);
        end
        drive(0, 1, 16'd55, 1, 16'd66, 1, 0);
        cyc();
        drive(0, 0, 16'h0, 0, 16'h0, 1, 0);
        cyc(); chk_word("mid_tie0", 1'b0, 16'd55);
        cyc(); chk_word("mid_tie1", 1'b1, 16'd66);
        cyc(); chk("mid_tie_done", 32'(bus.OUT_VALID), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/theremin_period_arbiter.md
# theremin_period_arbiter

Merges the half-period measurement streams of two sensor channels (pitch and volume antenna) into one tagged stream for a single shared downstream consumer, e.g. a filter or a register-file writer. Each channel's one-cycle measurement pulses are buffered in a per-channel FIFO. A round-robin arbiter feeds one registered output with a valid/ready handshake. Lost measurements are counted per channel. Sits in the CLK_PARALLEL domain, directly after the channel measurement blocks.

## Interface
Parameters:
- PERIOD_BITS, 16, width of period values
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, at least 2
- DROP_BITS, 8, width of each saturating drop counter

Ports:
- CLK_PARALLEL  in  1  200 MHz clock; all logic on its rising edge
- RESET  in  1  synchronous, active-high; clock CLK_PARALLEL
- CH0_VALID  in  1  one-cycle pulse, new channel-0 measurement
- CH0_PERIOD  in  PERIOD_BITS  channel-0 value, qualified by CH0_VALID
- CH1_VALID  in  1  one-cycle pulse, new channel-1 measurement
- CH1_PERIOD  in  PERIOD_BITS  channel-1 value, qualified by CH1_VALID
- OUT_READY  in  1  consumer accepts the output word this cycle
- CLEAR_DROPS  in  1  synchronous clear of both drop counters
- OUT_VALID  out  1  output word valid
- OUT_CHANNEL  out  1  source channel of the output word
- OUT_PERIOD  out  PERIOD_BITS  output period value
- CH0_DROPS  out  DROP_BITS  channel-0 measurements lost to a full FIFO
- CH1_DROPS  out  DROP_BITS  channel-1 measurements lost to a full FIFO

## Operation
- Each channel has a FIFO of FIFO_DEPTH entries, with a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Write: CHn_VALID=1 writes CHn_PERIOD when count<FIFO_DEPTH, or when that FIFO is popped in the same cycle. Otherwise the new value is dropped, the FIFO is unchanged, and CHn_DROPS increments.
- Drop counters saturate at 2^DROP_BITS-1. CLEAR_DROPS=1 loads 0, or loads 1 if a drop occurs on that channel in the same cycle.
- Output register (OUT_VALID, OUT_CHANNEL, OUT_PERIOD) is "free" when OUT_VALID=0 or OUT_READY=1.
- When free and at least one FIFO is non-empty, the arbiter pops one FIFO head into the output register and sets OUT_VALID=1.
- When free and both FIFOs are empty, OUT_VALID clears to 0.
- Arbitration: a single non-empty FIFO is granted. If both are non-empty, grant the channel other than last_grant, then set last_grant to the granted channel. last_grant resets to 1, so channel 0 wins the first tie.
- While OUT_VALID=1 and OUT_READY=0, OUT_CHANNEL and OUT_PERIOD hold stable. Nothing is popped.
- Per-channel order is preserved. There is no reordering within a channel.
- No bypass path: a value always passes through its FIFO.

## Timing
- Reset values: OUT_VALID=0, OUT_CHANNEL=0, OUT_PERIOD=0, CH0_DROPS=0, CH1_DROPS=0. Both FIFOs empty; last_grant=1.
- Reset mid-operation: all buffered and in-flight data is discarded. A CHn_VALID in the reset cycle is ignored and not counted.
- Latency: CHn_VALID high in cycle N (output free, other FIFO empty) -> OUT_VALID high in cycle N+2.
- Throughput: one output word per cycle while OUT_READY=1 and data is buffered.
- Simultaneous pulses on both channels in the same cycle are both accepted if space allows.
- Full FIFO with a pop in the same cycle: the write is accepted and count is unchanged.
- Capacity per channel before the first drop: FIFO_DEPTH + 1 words (FIFO plus the output register).

## Test plan
- Single word: CH0_VALID pulse with CH0_PERIOD=0x1234, OUT_READY=1 -> OUT_VALID=1 for exactly one cycle, two cycles later, with OUT_CHANNEL=0 and OUT_PERIOD=0x1234. Drop counters stay 0.
- Tie: CH0=100 and CH1=200 pulsed in the same cycle, OUT_READY=1 -> (0,100) then (1,200) on consecutive cycles.
- Backpressure and overflow: OUT_READY=0, six CH1 pulses with values 1..6, FIFO_DEPTH=4 -> CH1_DROPS=1. Then set OUT_READY=1 -> 1,2,3,4,5 appear in order, all OUT_CHANNEL=1, and OUT_PERIOD holds stable while stalled.
- Fairness: both channels pulsing every cycle, OUT_READY=1 -> OUT_CHANNEL alternates 0,1,0,1… Drops accumulate equally on both channels.
- Counter rules: 300 forced drops on CH0 with DROP_BITS=8 -> CH0_DROPS=255. CLEAR_DROPS asserted together with a CH0 drop -> CH0_DROPS=1 the next cycle.
- Reset mid-stream: three words buffered and OUT_VALID=1, then RESET for one cycle -> all outputs 0 the next cycle. No stale words emerge afterwards, and the next tie grants channel 0 first.
